alarm_trigger: RTL

//  Consumer side of the alarm-setting interface. Compares the stored alarm time (HH:MM,
//  BCD digits) against the running clock and drives the buzzer when they match.

---
 rtl/alarm_trigger_if.sv | 45 ++++
 rtl/alarm_trigger.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alarm_trigger_if.sv
// ============================================================================
// Module   : alarm_trigger_if
// Purpose  : Bundles the time, alarm-setting, button and buzzer signals
//            exchanged with the alarm trigger block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alarm_trigger_if;
   logic       sec_tick;
   logic [1:0] cur_hours_left;
   logic [3:0] cur_hours_right;
   logic [2:0] cur_min_left;
   logic [3:0] cur_min_right;
   logic [2:0] cur_sec_left;
   logic [3:0] cur_sec_right;
   logic [1:0] al_hours_left;
   logic [3:0] al_hours_right;
   logic [2:0] al_min_left;
   logic [3:0] al_min_right;
   logic       alarm_on;
   logic       alarm_setting;
   logic       stop_button;
   logic       snooze_button;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_count;

   modport master (
      output sec_tick, cur_hours_left, cur_hours_right, cur_min_left, cur_min_right,
             cur_sec_left, cur_sec_right, al_hours_left, al_hours_right, al_min_left,
             al_min_right, alarm_on, alarm_setting, stop_button, snooze_button,
      input  buzzer, ringing, snoozing, snooze_count
   );

   modport slave (
      input  sec_tick, cur_hours_left, cur_hours_right, cur_min_left, cur_min_right,
             cur_sec_left, cur_sec_right, al_hours_left, al_hours_right, al_min_left,
             al_min_right, alarm_on, alarm_setting, stop_button, snooze_button,
      output buzzer, ringing, snoozing, snooze_count
   );
endinterface

`default_nettype wire

// File: rtl/alarm_trigger.sv
// ============================================================================
// Module   : alarm_trigger
// Purpose  : Matches the running clock against the stored alarm time and runs
//            the ring / snooze / stop sequence driving the buzzer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_trigger #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300,
   parameter int MAX_SNOOZE     = 3
) (
   input wire logic      clk,
   input wire logic      rst,
   alarm_trigger_if.slave bus
);
   localparam int c_RW = $clog2(RING_SECONDS);
   localparam int c_SW = $clog2(SNOOZE_SECONDS);
   localparam logic [c_RW-1:0] c_RING_LAST = c_RW'(RING_SECONDS - 1);
   localparam logic [c_SW-1:0] c_SNZ_LAST  = c_SW'(SNOOZE_SECONDS - 1);
   localparam logic [1:0]      c_MAX_SNZ   = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_ARMED    = 2'd1,
      S_RINGING  = 2'd2,
      S_SNOOZE   = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_RW-1:0] r_ring_cnt, w_ring_cnt_nxt;
   logic [c_SW-1:0] r_snz_cnt, w_snz_cnt_nxt;
   logic [1:0]      r_snz_used, w_snz_used_nxt;
   logic            r_buzzer, w_buzzer_nxt;
   logic            r_match_q;
   logic            w_match_c;
   logic            w_trigger;

   // Seconds must be 00 so the match is a single one-second window per day.
   assign w_match_c = (bus.cur_hours_left  == bus.al_hours_left)  &&
                      (bus.cur_hours_right == bus.al_hours_right) &&
                      (bus.cur_min_left    == bus.al_min_left)    &&
                      (bus.cur_min_right   == bus.al_min_right)   &&
                      (bus.cur_sec_left    == 3'd0)               &&
                      (bus.cur_sec_right   == 4'd0);
   assign w_trigger = w_match_c & ~r_match_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_DISARMED;
         r_ring_cnt <= '0;
         r_snz_cnt  <= '0;
         r_snz_used <= '0;
         r_buzzer   <= 1'b0;
         r_match_q  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ring_cnt <= w_ring_cnt_nxt;
         r_snz_cnt  <= w_snz_cnt_nxt;
         r_snz_used <= w_snz_used_nxt;
         r_buzzer   <= w_buzzer_nxt;
         r_match_q  <= w_match_c;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ring_cnt_nxt = r_ring_cnt;
      w_snz_cnt_nxt  = r_snz_cnt;
      w_snz_used_nxt = r_snz_used;
      w_buzzer_nxt   = r_buzzer;
      if (!bus.alarm_on || bus.alarm_setting) begin
         w_state_nxt    = S_DISARMED;
         w_ring_cnt_nxt = '0;
         w_snz_cnt_nxt  = '0;
         w_snz_used_nxt = '0;
         w_buzzer_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_DISARMED: w_state_nxt = S_ARMED;
            S_ARMED: begin
               if (w_trigger) begin
                  w_state_nxt    = S_RINGING;
                  w_ring_cnt_nxt = '0;
                  w_buzzer_nxt   = 1'b1;
               end
            end
            S_RINGING: begin
               // Stop beats snooze beats timeout; a snooze at the limit falls through.
               if (bus.stop_button) begin
                  w_state_nxt    = S_ARMED;
                  w_buzzer_nxt   = 1'b0;
                  w_snz_used_nxt = '0;
               end else if (bus.snooze_button && (r_snz_used < c_MAX_SNZ)) begin
                  w_state_nxt    = S_SNOOZE;
                  w_snz_cnt_nxt  = '0;
                  w_snz_used_nxt = r_snz_used + 2'd1;
                  w_buzzer_nxt   = 1'b0;
               end else if (bus.sec_tick) begin
                  if (r_ring_cnt == c_RING_LAST) begin
                     w_state_nxt    = S_ARMED;
                     w_buzzer_nxt   = 1'b0;
                     w_snz_used_nxt = '0;
                  end else begin
                     w_buzzer_nxt   = ~r_buzzer;
                     w_ring_cnt_nxt = r_ring_cnt + 1'b1;
                  end
               end
            end
            S_SNOOZE: begin
               if (bus.stop_button) begin
                  w_state_nxt    = S_ARMED;
                  w_snz_used_nxt = '0;
               end else if (bus.sec_tick) begin
                  if (r_snz_cnt == c_SNZ_LAST) begin
                     w_state_nxt    = S_RINGING;
                     w_ring_cnt_nxt = '0;
                     w_buzzer_nxt   = 1'b1;
                  end else begin
                     w_snz_cnt_nxt = r_snz_cnt + 1'b1;
                  end
               end
            end
            default: w_state_nxt = S_DISARMED;
         endcase
      end
   end

   assign bus.buzzer       = r_buzzer;
   assign bus.ringing      = (r_state == S_RINGING);
   assign bus.snoozing     = (r_state == S_SNOOZE);
   assign bus.snooze_count = r_snz_used;

endmodule

`default_nettype wire
